bus_transfer_sequencer: RTL and testbench

- Command-driven controller sitting directly upstream of the 8-bit register/accumulator bus block (R1, R2, R3, Acc).
- Generates every Sel*/RnW* strobe for that block and sources or sinks its external data pins (DioExt), split into in, out and enable here; the top level wraps them into the tri-state.
- Executes three operations, one at a time, under a valid/ready handshake: load an immediate into a unit, move data between units, read a unit back to the host.

---
 rtl/bus_transfer_sequencer.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sequencer.sv
// ---------------------------------------------------------------------------
// bus_transfer_sequencer
//
// Command-driven controller for the 8-bit R1/R2/R3/Acc register bus block.
// It accepts one command at a time over a valid/ready handshake and
// sequences the Sel*/RnW* strobes and the external data pins of that block
// to LOAD an immediate, MOVE a unit into another, or READ a unit back.
//
// Ports:
//   Clock, Reset              rising-edge clock, synchronous active-high reset
//   CmdValid/CmdReady         command handshake (ready in IDLE and FIN)
//   CmdOp/CmdSrc/CmdDst       0=LOAD 1=MOVE 2=READ 3=NOP; units 0=R1 1=R2 2=R3 3=Acc
//   CmdData                   LOAD immediate
//   RdValid/RdData            READ result, one-cycle valid pulse
//   Done                      one-cycle pulse when a command completes
//   Err                       verify mismatch pulse (0 unless SEQ_VERIFY_EN)
//   Sel1..SelAcc, RnW1..RnWAcc  unit strobes toward the bus block
//   DinExt/DoutExt/DoutEn     split external data pins (wrapped to tri-state above)
//
// Parameters: DW data width, SETTLE cycles per bus phase (1..15).
//
// Build option: define SEQ_VERIFY_EN to re-read the destination after every
// LOAD/MOVE write (WR -> TURN -> VRD -> FIN) and flag a mismatch on Err.
//
// All outputs are driven straight from flops; the next-cycle output values
// are decoded from the next state.
// ---------------------------------------------------------------------------
module bus_transfer_sequencer #(
    parameter int DW     = 8,
    parameter int SETTLE = 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          CmdValid,
    output logic          CmdReady,
    input  logic [1:0]    CmdOp,
    input  logic [1:0]    CmdSrc,
    input  logic [1:0]    CmdDst,
    input  logic [DW-1:0] CmdData,
    output logic          RdValid,
    output logic [DW-1:0] RdData,
    output logic          Done,
    output logic          Err,
    output logic          Sel1,
    output logic          Sel2,
    output logic          Sel3,
    output logic          SelAcc,
    output logic          RnW1,
    output logic          RnW2,
    output logic          RnW3,
    output logic          RnWAcc,
    input  logic [DW-1:0] DinExt,
    output logic [DW-1:0] DoutExt,
    output logic          DoutEn
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_TURN = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;
`ifdef SEQ_VERIFY_EN
    localparam logic [2:0] ST_VRD  = 3'd5;
`endif

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_MOVE = 2'd1;
    localparam logic [1:0] OP_READ = 2'd2;
    localparam logic [1:0] OP_NOP  = 2'd3;

    // Last phase cycle is reached when the counter equals SETTLE-1.
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    // Unit code to select vector bit: [0]=R1 [1]=R2 [2]=R3 [3]=Acc.
    function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
        case (unit)
            2'd0:    unit_onehot = 4'b0001;
            2'd1:    unit_onehot = 4'b0010;
            2'd2:    unit_onehot = 4'b0100;
            2'd3:    unit_onehot = 4'b1000;
            default: unit_onehot = 4'b0000;
        endcase
    endfunction

    logic [2:0]    state_r, state_nxt_s;
    logic [3:0]    cnt_r, cnt_nxt_s;
    logic [1:0]    op_r, op_nxt_s;
    logic [1:0]    src_r, src_nxt_s;
    logic [1:0]    dst_r, dst_nxt_s;
    logic [DW-1:0] hold_r, hold_nxt_s;
    logic [DW-1:0] rd_data_r, rd_data_nxt_s;
    logic          rd_valid_r, rd_valid_nxt_s;
    logic          done_r, done_nxt_s;
    logic          ready_r, ready_nxt_s;
    logic [3:0]    sel_r, sel_nxt_s;
    logic [3:0]    rnw_r, rnw_nxt_s;
    logic [DW-1:0] dout_r, dout_nxt_s;
    logic          dout_en_r, dout_en_nxt_s;
    logic          accept_s;
    logic          last_s;
`ifdef SEQ_VERIFY_EN
    logic          vfy_r, vfy_nxt_s;
    logic          err_r, err_nxt_s;
`endif

    assign accept_s = CmdValid & ready_r;
    assign last_s   = (cnt_r == SETTLE_M1);

    // Next-state, phase counter and captured command fields.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = 4'd0;
        op_nxt_s    = op_r;
        src_nxt_s   = src_r;
        dst_nxt_s   = dst_r;
        hold_nxt_s  = hold_r;
`ifdef SEQ_VERIFY_EN
        vfy_nxt_s   = vfy_r;
        err_nxt_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE, ST_FIN: begin
                if (accept_s) begin
                    op_nxt_s  = CmdOp;
                    src_nxt_s = CmdSrc;
                    dst_nxt_s = CmdDst;
`ifdef SEQ_VERIFY_EN
                    vfy_nxt_s = 1'b0;
`endif
                    case (CmdOp)
                        OP_LOAD: begin
                            hold_nxt_s  = CmdData;
                            state_nxt_s = ST_WR;
                        end
                        OP_MOVE: state_nxt_s = ST_RD;
                        OP_READ: state_nxt_s = ST_RD;
                        OP_NOP:  state_nxt_s = ST_FIN;
                        default: state_nxt_s = ST_FIN;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (last_s) begin
                    hold_nxt_s = DinExt;
                    if (op_r == OP_MOVE) begin
                        state_nxt_s = ST_TURN;
                    end else begin
                        state_nxt_s = ST_FIN;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end
            end
            ST_TURN: begin
`ifdef SEQ_VERIFY_EN
                // TURN is shared: before the write (MOVE) and before the verify read.
                if (vfy_r) begin
                    state_nxt_s = ST_VRD;
                end else begin
                    state_nxt_s = ST_WR;
                end
`else
                state_nxt_s = ST_WR;
`endif
            end
            ST_WR: begin
                if (last_s) begin
`ifdef SEQ_VERIFY_EN
                    vfy_nxt_s   = 1'b1;
                    state_nxt_s = ST_TURN;
`else
                    state_nxt_s = ST_FIN;
`endif
                end else begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end
            end
`ifdef SEQ_VERIFY_EN
            ST_VRD: begin
                if (last_s) begin
                    err_nxt_s   = (DinExt != hold_r);
                    state_nxt_s = ST_FIN;
                end else begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end
            end
`endif
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output values for the cycle that follows, decoded from the next state.
    always_comb begin
        sel_nxt_s      = 4'b0000;
        rnw_nxt_s      = 4'b1111;
        dout_nxt_s     = {DW{1'b0}};
        dout_en_nxt_s  = 1'b0;
        done_nxt_s     = 1'b0;
        rd_valid_nxt_s = 1'b0;
        rd_data_nxt_s  = rd_data_r;
        ready_nxt_s    = 1'b0;
        case (state_nxt_s)
            ST_IDLE: ready_nxt_s = 1'b1;
            ST_RD:   sel_nxt_s = unit_onehot(src_nxt_s);
`ifdef SEQ_VERIFY_EN
            ST_VRD:  sel_nxt_s = unit_onehot(dst_nxt_s);
`endif
            ST_WR: begin
                // The bus block only routes external data inward when every RnW is 0.
                sel_nxt_s     = unit_onehot(dst_nxt_s);
                rnw_nxt_s     = 4'b0000;
                dout_nxt_s    = hold_nxt_s;
                dout_en_nxt_s = 1'b1;
            end
            ST_FIN: begin
                done_nxt_s  = 1'b1;
                ready_nxt_s = 1'b1;
                if (op_nxt_s == OP_READ) begin
                    rd_valid_nxt_s = 1'b1;
                    rd_data_nxt_s  = hold_nxt_s;
                end else begin
                    rd_valid_nxt_s = 1'b0;
                end
            end
            default: sel_nxt_s = 4'b0000;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            op_r       <= OP_NOP;
            src_r      <= 2'd0;
            dst_r      <= 2'd0;
            hold_r     <= {DW{1'b0}};
            rd_data_r  <= {DW{1'b0}};
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
            ready_r    <= 1'b1;
            sel_r      <= 4'b0000;
            rnw_r      <= 4'b1111;
            dout_r     <= {DW{1'b0}};
            dout_en_r  <= 1'b0;
`ifdef SEQ_VERIFY_EN
            vfy_r      <= 1'b0;
            err_r      <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            op_r       <= op_nxt_s;
            src_r      <= src_nxt_s;
            dst_r      <= dst_nxt_s;
            hold_r     <= hold_nxt_s;
            rd_data_r  <= rd_data_nxt_s;
            rd_valid_r <= rd_valid_nxt_s;
            done_r     <= done_nxt_s;
            ready_r    <= ready_nxt_s;
            sel_r      <= sel_nxt_s;
            rnw_r      <= rnw_nxt_s;
            dout_r     <= dout_nxt_s;
            dout_en_r  <= dout_en_nxt_s;
`ifdef SEQ_VERIFY_EN
            vfy_r      <= vfy_nxt_s;
            err_r      <= err_nxt_s;
`endif
        end
    end

    assign CmdReady = ready_r;
    assign RdValid  = rd_valid_r;
    assign RdData   = rd_data_r;
    assign Done     = done_r;
    assign Sel1     = sel_r[0];
    assign Sel2     = sel_r[1];
    assign Sel3     = sel_r[2];
    assign SelAcc   = sel_r[3];
    assign RnW1     = rnw_r[0];
    assign RnW2     = rnw_r[1];
    assign RnW3     = rnw_r[2];
    assign RnWAcc   = rnw_r[3];
    assign DoutExt  = dout_r;
    assign DoutEn   = dout_en_r;
`ifdef SEQ_VERIFY_EN
    assign Err      = err_r;
`else
    assign Err      = 1'b0;
`endif

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for bus_transfer_sequencer.
// u1 (SETTLE=1) is attached to a small R1/R2/R3/Acc register model so data
// written by LOAD/MOVE can be read back; u3 (SETTLE=3) covers longer phases
// and reset in the middle of a write.
// ---------------------------------------------------------------------------
module tb_bus_transfer_sequencer;

    logic       clk;
    logic       rst, rst3;
    logic       valid1, valid3;
    logic [1:0] op, src, dst;
    logic [7:0] data;
    logic       force_bad;

    logic       ready1, rd_valid1, done1, err1, en1;
    logic [7:0] rd_data1, dout1, din1;
    logic [3:0] sel1, rnw1;

    logic       ready3, rd_valid3, done3, err3, en3;
    logic [7:0] rd_data3, dout3, din3;
    logic [3:0] sel3, rnw3;

    logic [7:0] regs [4];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bus_transfer_sequencer #(.DW(8), .SETTLE(1)) u1 (
        .Clock(clk), .Reset(rst), .CmdValid(valid1), .CmdReady(ready1),
        .CmdOp(op), .CmdSrc(src), .CmdDst(dst), .CmdData(data),
        .RdValid(rd_valid1), .RdData(rd_data1), .Done(done1), .Err(err1),
        .Sel1(sel1[0]), .Sel2(sel1[1]), .Sel3(sel1[2]), .SelAcc(sel1[3]),
        .RnW1(rnw1[0]), .RnW2(rnw1[1]), .RnW3(rnw1[2]), .RnWAcc(rnw1[3]),
        .DinExt(din1), .DoutExt(dout1), .DoutEn(en1)
    );

    bus_transfer_sequencer #(.DW(8), .SETTLE(3)) u3 (
        .Clock(clk), .Reset(rst3), .CmdValid(valid3), .CmdReady(ready3),
        .CmdOp(op), .CmdSrc(src), .CmdDst(dst), .CmdData(data),
        .RdValid(rd_valid3), .RdData(rd_data3), .Done(done3), .Err(err3),
        .Sel1(sel3[0]), .Sel2(sel3[1]), .Sel3(sel3[2]), .SelAcc(sel3[3]),
        .RnW1(rnw3[0]), .RnW2(rnw3[1]), .RnW3(rnw3[2]), .RnWAcc(rnw3[3]),
        .DinExt(din3), .DoutExt(dout3), .DoutEn(en3)
    );

    assign din3 = 8'h5A;

    // Register model: written when the sequencer drives a write phase.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else if (en1 && rnw1 == 4'h0) begin
            case (sel1)
                4'b0001: regs[0] <= dout1;
                4'b0010: regs[1] <= dout1;
                4'b0100: regs[2] <= dout1;
                4'b1000: regs[3] <= dout1;
                default: ;
            endcase
        end
    end

    // Register model read path; force_bad corrupts it for the verify test.
    always_comb begin
        din1 = 8'h00;
        if (!force_bad && rnw1 == 4'hF) begin
            case (sel1)
                4'b0001: din1 = regs[0];
                4'b0010: din1 = regs[1];
                4'b0100: din1 = regs[2];
                4'b1000: din1 = regs[3];
                default: din1 = 8'h00;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bus invariants on every cycle: one select at most, drive only in a write.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ($countones(sel1) <= 1) else begin
                failures++;
                $error("FAIL onehot_u1 observed=0x%0h expected=at_most_one", sel1);
            end
            checks++;
            assert (!en1 || (rnw1 == 4'h0 && sel1 != 4'h0)) else begin
                failures++;
                $error("FAIL douten_u1 observed=en%0b_rnw%0h_sel%0h expected=write_only", en1, rnw1, sel1);
            end
        end
        if (!rst3) begin
            checks++;
            assert ($countones(sel3) <= 1 && (!en3 || rnw3 == 4'h0)) else begin
                failures++;
                $error("FAIL bus_u3 observed=sel%0h_en%0b_rnw%0h expected=legal", sel3, en3, rnw3);
            end
        end
    end

    initial begin
        rst = 1'b1; rst3 = 1'b1; valid1 = 1'b0; valid3 = 1'b0;
        op = 2'd0; src = 2'd0; dst = 2'd0; data = 8'h00; force_bad = 1'b0;
        tick; tick;
        chk("rst_sel", {28'd0, sel1}, 32'h0);
        chk("rst_rnw", {28'd0, rnw1}, 32'hF);
        chk("rst_en", {31'd0, en1}, 32'h0);
        chk("rst_dout", {24'd0, dout1}, 32'h0);
        chk("rst_pulses", {29'd0, done1, rd_valid1, err1}, 32'h0);
        chk("rst_rddata", {24'd0, rd_data1}, 32'h0);
        chk("rst_ready", {31'd0, ready1}, 32'h1);
        rst = 1'b0; rst3 = 1'b0;
        tick;

`ifdef SEQ_VERIFY_EN
        // LOAD 0x3C into R1 with a corrupted verify read.
        valid1 = 1'b1; op = 2'd0; dst = 2'd0; data = 8'h3C;
        tick; valid1 = 1'b0;
        chk("v_wr_sel", {28'd0, sel1}, 32'h1);
        tick;
        chk("v_turn_sel", {28'd0, sel1}, 32'h0);
        force_bad = 1'b1;
        tick;
        chk("v_vrd_sel", {28'd0, sel1}, 32'h1);
        chk("v_vrd_rnw", {28'd0, rnw1}, 32'hF);
        tick;
        force_bad = 1'b0;
        chk("v_bad_err", {31'd0, err1}, 32'h1);
        chk("v_bad_done", {31'd0, done1}, 32'h1);
        tick;
        chk("v_err_clr", {31'd0, err1}, 32'h0);
        // Same LOAD with correct read-back.
        valid1 = 1'b1;
        tick; valid1 = 1'b0;
        tick; tick; tick;
        chk("v_ok_done", {31'd0, done1}, 32'h1);
        chk("v_ok_err", {31'd0, err1}, 32'h0);
        tick;
`else
        // LOAD 0xA5 into R2 (src ignored).
        valid1 = 1'b1; op = 2'd0; src = 2'd3; dst = 2'd1; data = 8'hA5;
        tick; valid1 = 1'b0;
        chk("ld_wr_sel", {28'd0, sel1}, 32'h2);
        chk("ld_wr_rnw", {28'd0, rnw1}, 32'h0);
        chk("ld_wr_en", {31'd0, en1}, 32'h1);
        chk("ld_wr_dout", {24'd0, dout1}, 32'hA5);
        chk("ld_wr_ready", {31'd0, ready1}, 32'h0);
        chk("ld_wr_done", {31'd0, done1}, 32'h0);
        tick;
        chk("ld_fin_done", {31'd0, done1}, 32'h1);
        chk("ld_fin_rnw", {28'd0, rnw1}, 32'hF);
        chk("ld_fin_sel", {28'd0, sel1}, 32'h0);
        chk("ld_fin_ready", {31'd0, ready1}, 32'h1);
        chk("ld_fin_err", {31'd0, err1}, 32'h0);
        tick;
        chk("ld_idle_done", {31'd0, done1}, 32'h0);

        // READ R2.
        valid1 = 1'b1; op = 2'd2; src = 2'd1; dst = 2'd3;
        tick; valid1 = 1'b0;
        chk("rd_sel", {28'd0, sel1}, 32'h2);
        chk("rd_rnw", {28'd0, rnw1}, 32'hF);
        chk("rd_en", {31'd0, en1}, 32'h0);
        tick;
        chk("rd_fin_valid", {31'd0, rd_valid1}, 32'h1);
        chk("rd_fin_data", {24'd0, rd_data1}, 32'hA5);
        chk("rd_fin_done", {31'd0, done1}, 32'h1);
        tick;
        chk("rd_after_valid", {31'd0, rd_valid1}, 32'h0);
        chk("rd_after_data", {24'd0, rd_data1}, 32'hA5);

        // Back-to-back LOADs with CmdValid held: R1=0x11 then R3=0x22.
        valid1 = 1'b1; op = 2'd0; dst = 2'd0; data = 8'h11;
        tick;
        chk("b2b_wr1_sel", {28'd0, sel1}, 32'h1);
        chk("b2b_wr1_dout", {24'd0, dout1}, 32'h11);
        dst = 2'd2; data = 8'h22;
        tick;
        chk("b2b_fin1_done", {31'd0, done1}, 32'h1);
        chk("b2b_fin1_ready", {31'd0, ready1}, 32'h1);
        tick; valid1 = 1'b0;
        chk("b2b_wr2_sel", {28'd0, sel1}, 32'h4);
        chk("b2b_wr2_dout", {24'd0, dout1}, 32'h22);
        chk("b2b_wr2_done", {31'd0, done1}, 32'h0);
        tick;
        chk("b2b_fin2_done", {31'd0, done1}, 32'h1);
        tick;

        // READ R3 returns the second LOAD.
        valid1 = 1'b1; op = 2'd2; src = 2'd2;
        tick; valid1 = 1'b0;
        tick;
        chk("rd3_data", {24'd0, rd_data1}, 32'h22);
        tick;

        // MOVE R2 -> Acc.
        valid1 = 1'b1; op = 2'd1; src = 2'd1; dst = 2'd3;
        tick; valid1 = 1'b0;
        chk("mv_rd_sel", {28'd0, sel1}, 32'h2);
        tick;
        chk("mv_turn_sel", {28'd0, sel1}, 32'h0);
        chk("mv_turn_rnw", {28'd0, rnw1}, 32'hF);
        chk("mv_turn_done", {31'd0, done1}, 32'h0);
        tick;
        chk("mv_wr_sel", {28'd0, sel1}, 32'h8);
        chk("mv_wr_rnw", {28'd0, rnw1}, 32'h0);
        chk("mv_wr_dout", {24'd0, dout1}, 32'hA5);
        tick;
        chk("mv_fin_done", {31'd0, done1}, 32'h1);
        chk("mv_fin_rdvalid", {31'd0, rd_valid1}, 32'h0);
        tick;

        // READ Acc shows the moved value.
        valid1 = 1'b1; op = 2'd2; src = 2'd3;
        tick; valid1 = 1'b0;
        chk("rdacc_sel", {28'd0, sel1}, 32'h8);
        tick;
        chk("rdacc_data", {24'd0, rd_data1}, 32'hA5);
        tick;

        // NOP completes one cycle after acceptance.
        valid1 = 1'b1; op = 2'd3;
        tick; valid1 = 1'b0;
        chk("nop_done", {31'd0, done1}, 32'h1);
        chk("nop_sel", {28'd0, sel1}, 32'h0);
        chk("nop_rdvalid", {31'd0, rd_valid1}, 32'h0);
        tick;
        chk("nop_idle", {31'd0, done1}, 32'h0);
`endif

        // SETTLE=3: MOVE R1 -> R3, reset during the second write cycle.
        valid3 = 1'b1; op = 2'd1; src = 2'd0; dst = 2'd2;
        tick; valid3 = 1'b0;
        chk("s3_rd1_sel", {28'd0, sel3}, 32'h1);
        tick; tick;
        chk("s3_rd3_sel", {28'd0, sel3}, 32'h1);
        tick;
        chk("s3_turn_sel", {28'd0, sel3}, 32'h0);
        tick;
        chk("s3_wr1_sel", {28'd0, sel3}, 32'h4);
        chk("s3_wr1_en", {31'd0, en3}, 32'h1);
        tick;
        chk("s3_wr2_sel", {28'd0, sel3}, 32'h4);
        chk("s3_wr2_rnw", {28'd0, rnw3}, 32'h0);
        rst3 = 1'b1;
        tick;
        chk("s3_rst_sel", {28'd0, sel3}, 32'h0);
        chk("s3_rst_rnw", {28'd0, rnw3}, 32'hF);
        chk("s3_rst_en", {31'd0, en3}, 32'h0);
        chk("s3_rst_done", {31'd0, done3}, 32'h0);
        chk("s3_rst_ready", {31'd0, ready3}, 32'h1);
        rst3 = 1'b0;
        tick;
        chk("s3_after_done", {31'd0, done3}, 32'h0);
        chk("s3_after_ready", {31'd0, ready3}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
